// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner for the alarm clock.
// Time digits are snapshotted once per scan frame so a digit never tears mid-frame.
// Optional alarm flash is enabled by defining ALARM_FLASH_EN.
module clock_display_scan #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] qh1,
  input  logic [3:0] qh0,
  input  logic [3:0] qm1,
  input  logic [3:0] qm0,
  input  logic [3:0] qs1,
  input  logic [3:0] qs0,
  input  logic       alarm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int unsigned PcW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PcW-1:0] PcMax = PcW'(PRESCALE - 1);

  logic [PcW-1:0]  pc_q, pc_d;
  logic [2:0]      digit_idx_q, digit_idx_d;
  logic            frame_done_q, frame_done_d;
  logic            load_pending_q, load_pending_d;
  logic [5:0][3:0] snap_q, snap_d;
  logic            alarm_snap_q, alarm_snap_d;
  logic [6:0]      seg_q, seg_d;
  logic [5:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic            tick;
  logic            blank;
  logic [3:0]      cur_digit;

  // Prescaler, scan index and frame-boundary snapshot control.
  always_comb begin
    tick           = (pc_q == PcMax);
    pc_d           = tick ? '0 : pc_q + 1'b1;
    digit_idx_d    = digit_idx_q;
    frame_done_d   = 1'b0;
    load_pending_d = 1'b0;
    snap_d         = snap_q;
    alarm_snap_d   = alarm_snap_q;
    if (tick) begin
      if (digit_idx_q == 3'd5) begin
        digit_idx_d    = 3'd0;
        frame_done_d   = 1'b1;
        load_pending_d = 1'b1;
      end else begin
        digit_idx_d = digit_idx_q + 3'd1;
      end
    end
    if (load_pending_q) begin
      snap_d       = {qs0, qs1, qm0, qm1, qh0, qh1};
      alarm_snap_d = alarm;
    end
  end

`ifdef ALARM_FLASH_EN
  localparam int unsigned FcW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FcW-1:0] FcMax = FcW'(FLASH_FRAMES - 1);

  logic [FcW-1:0] flash_cnt_q, flash_cnt_d;
  logic           phase_q, phase_d;

  // Frame counter toggles the flash phase; held at the lit phase while no alarm.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    phase_d     = phase_q;
    if (!alarm_snap_q) begin
      flash_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (frame_done_q) begin
      if (flash_cnt_q == FcMax) begin
        flash_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
      end
    end
    blank = alarm_snap_q & phase_q;
  end

  // Flash state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  // Without flashing, the alarm snapshot is kept but never reaches the outputs.
  logic unused_flash;
  assign unused_flash = alarm_snap_q ^ FLASH_FRAMES[0];
  assign blank        = 1'b0;
`endif

  // Segment decode, digit enable and separator dot for the current index.
  always_comb begin
    case (digit_idx_q)
      3'd0:    cur_digit = snap_q[0];
      3'd1:    cur_digit = snap_q[1];
      3'd2:    cur_digit = snap_q[2];
      3'd3:    cur_digit = snap_q[3];
      3'd4:    cur_digit = snap_q[4];
      3'd5:    cur_digit = snap_q[5];
      default: cur_digit = 4'hF;
    endcase
    case (cur_digit)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h40; // non-BCD shows a dash
    endcase
    an_d = blank ? 6'd0 : (6'd1 << digit_idx_q);
    dp_d = !blank && ((digit_idx_q == 3'd1) || (digit_idx_q == 3'd3));
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= '0;
      digit_idx_q    <= 3'd0;
      frame_done_q   <= 1'b0;
      load_pending_q <= 1'b1;
      snap_q         <= '0;
      alarm_snap_q   <= 1'b0;
      seg_q          <= 7'd0;
      an_q           <= 6'd0;
      dp_q           <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      digit_idx_q    <= digit_idx_d;
      frame_done_q   <= frame_done_d;
      load_pending_q <= load_pending_d;
      snap_q         <= snap_d;
      alarm_snap_q   <= alarm_snap_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      dp_q           <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomised self-checking bench for clock_display_scan with a time-based reference model.
module tb_clock_display_scan;

  localparam int unsigned P  = 4;
  localparam int unsigned F  = 2;
  localparam int unsigned FP = 6 * P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din [6];
  logic       alarm = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic [2:0] digit_idx;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // Model state: t = clock edges since reset release.
  int         t;
  logic [3:0] m_snap [6];
  logic       m_asnap;
  int         m_cnt;
  logic       m_phase;
  logic [6:0] seg_tab [16];

  clock_display_scan #(
    .PRESCALE    (P),
    .FLASH_FRAMES(F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .qh1       (din[0]),
    .qh0       (din[1]),
    .qm1       (din[2]),
    .qm0       (din[3]),
    .qs1       (din[4]),
    .qs0       (din[5]),
    .alarm     (alarm),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'd0);
    check({tag, "_an"}, 32'(an), 32'd0);
    check({tag, "_dp"}, 32'(dp), 32'd0);
    check({tag, "_idx"}, 32'(digit_idx), 32'd0);
    check({tag, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  task automatic model_reset();
    t       = 0;
    m_asnap = 1'b0;
    m_cnt   = 0;
    m_phase = 1'b0;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
  endtask

  // One clock edge: predict, advance, compare. Called at a negedge, returns at a negedge.
  task automatic step();
    int         idx;
    logic       blank;
    logic [6:0] e_seg;
    logic [5:0] e_an;
    logic       e_dp;
    int         e_idx;
    logic       e_fd;
    logic       fd_pre;
    logic       load;
    idx    = (t / P) % 6;
    blank  = 1'b0;
`ifdef ALARM_FLASH_EN
    blank  = m_asnap && m_phase;
`endif
    e_seg  = seg_tab[m_snap[idx]];
    e_an   = blank ? 6'd0 : (6'd1 << idx);
    e_dp   = !blank && (idx == 1 || idx == 3);
    e_idx  = ((t + 1) / P) % 6;
    e_fd   = ((t + 1) % FP) == 0;
    fd_pre = (t > 0) && (t % FP == 0);
    load   = (t % FP) == 0;
`ifdef ALARM_FLASH_EN
    if (!m_asnap) begin
      m_cnt   = 0;
      m_phase = 1'b0;
    end else if (fd_pre) begin
      m_cnt++;
      if (m_cnt == F) begin
        m_cnt   = 0;
        m_phase = !m_phase;
      end
    end
`else
    if (fd_pre) m_cnt = 0;
`endif
    if (load) begin
      m_snap  = din;
      m_asnap = alarm;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("dp", 32'(dp), 32'(e_dp));
    check("digit_idx", 32'(digit_idx), 32'(e_idx));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    t++;
    @(negedge clk);
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(0, 15));
    alarm = 1'($urandom_range(0, 1));
    model_reset();

    // Reset held for three cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 12:34:56, two full frames.
    din   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    alarm = 1'b0;
    repeat (2 * FP) step();

    // Change qm0 while index 3 is shown; must only appear next frame.
    din[3] = 4'd4;
    repeat (2 * FP) begin
      if ((t % FP) / P == 3 && (t % P) == 1) din[3] = 4'd7;
      step();
    end

    // Non-BCD digit shows a dash.
    din[4] = 4'hB;
    repeat (2 * FP) step();

    // Alarm held: flash pattern, then drop alarm.
    alarm = 1'b1;
    repeat (9 * FP) step();
    alarm = 1'b0;
    repeat (2 * FP) step();

    // Random frames with random mid-frame input changes.
    repeat (12) begin
      alarm = 1'($urandom_range(0, 1));
      for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(0, 15));
      repeat (FP) begin
        if ($urandom_range(0, 4) == 0) din[$urandom_range(0, 5)] = 4'($urandom_range(0, 15));
        step();
      end
    end

    // Asynchronous reset while index 4 is held.
    while ((t / P) % 6 != 4) step();
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    alarm = 1'b0;
    for (int i = 0; i < 6; i++) din[i] = 4'($urandom_range(0, 9));
    repeat (2 * FP) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed six-digit seven-segment display scanner for the digital alarm clock. It reads the clock's six BCD time digits and the `alarm` flag and drives one shared segment bus plus six digit enables, one digit at a time. The six digits are snapshotted once per scan frame so the display never tears. It sits between the timekeeping counter and the board's LED display pins.

## Interface

**Parameters**
- `PRESCALE`, default 4: clk cycles each digit is held. Legal range ≥ 2. The counter width is `$clog2(PRESCALE)`.
- `FLASH_FRAMES`, default 8: scan frames per alarm flash half-period. Legal range ≥ 1. Used only with `ALARM_FLASH_EN`.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `qh1, qh0, qm1, qm0, qs1, qs0`  in  4 each: BCD time digits (hours tens to seconds units).
- `alarm`  in  1: alarm-match flag from the clock.
- `seg`  out  7: segments, active-high; `seg[6:0]` = g,f,e,d,c,b,a.
- `dp`  out  1: decimal point, active-high.
- `an`  out  6: one-hot digit enable, active-high. `an[k]` selects digit index k.
- `digit_idx`  out  3: index currently held by the scan counter.
- `frame_done`  out  1: one-cycle pulse when the scan wraps from index 5 to index 0.

## Operation

- **Digit index map:** 0=`qh1`, 1=`qh0`, 2=`qm1`, 3=`qm0`, 4=`qs1`, 5=`qs0`.
- **Prescaler `pc`:**
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` = (`pc` == PRESCALE-1).
- **Index counter `digit_idx`:**
  - Advances by 1 on `tick`.
  - On `tick` at index 5 it wraps to 0, asserts `frame_done` for one cycle and sets `load_pending`.
- **Snapshot:**
  - Six 4-bit registers plus `alarm_snap`.
  - Loaded from the inputs on any posedge where `load_pending` = 1; `load_pending` then clears.
  - `load_pending` resets to 1, so the first posedge after reset loads the snapshot.
  - Input changes at any other time are ignored until the next frame.
- **Decode:**
  - Values 0–9 map to 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
  - Values 10–15 display a dash (7'h40).
- **Decimal point:** `dp` = 1 when the displayed index is 1 or 3 (hh.mm.ss separators); otherwise 0.
- **Output registers:**
  - `seg`, `an` and `dp` are registered.
  - Each cycle they are computed from the current `digit_idx` and the current snapshot contents.

## Timing

- **Reset values:**
  - Outputs: `seg`=0, `an`=0, `dp`=0, `digit_idx`=0, `frame_done`=0.
  - Internal state: `pc`=0, all snapshot digits 0, `alarm_snap`=0, `load_pending`=1, flash counter 0, `phase`=0.
- **First edge after reset release:**
  - The snapshot loads.
  - Outputs show index 0 computed from the pre-load snapshot: `seg`=3F, `an`=000001.
- **Output latency:** outputs follow `digit_idx` and the snapshot by 1 clk.
- **Timing figures:**
  - Digit dwell: PRESCALE cycles.
  - Frame period: 6×PRESCALE cycles.
  - `frame_done` spacing: 6×PRESCALE cycles.
- **Snapshot timing:**
  - Inputs are sampled on the edge after `frame_done` rises, i.e. the first cycle of index 0.
  - The new values first appear on `seg` one edge later.
- **Simultaneous events:** a `tick` at index 5 in the same cycle as `load_pending` cannot occur, because `load_pending` clears within one cycle and PRESCALE ≥ 2.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronously). The scan restarts at index 0 with a fresh snapshot load.

## Configuration

- **`ALARM_FLASH_EN` defined:**
  - A frame counter counts `frame_done` pulses while `alarm_snap` = 1 and toggles `phase` every FLASH_FRAMES frames.
  - While `alarm_snap` = 1 and `phase` = 1: `an` = 0 and `dp` = 0; `seg` is still driven.
  - While `alarm_snap` = 0: the counter and `phase` are held at 0, so a new alarm starts in the lit phase.
- **`ALARM_FLASH_EN` undefined:**
  - No frame counter and no `phase` register are built.
  - `alarm` and `alarm_snap` have no effect on the outputs.

## Test plan

- **Reset:** hold `rst` for 3 cycles with random digits → `seg`=0, `an`=0, `dp`=0, `digit_idx`=0, `frame_done`=0 throughout.
- **Scan sequence:**
  - Stimulus: PRESCALE=4, inputs 12:34:56, release reset, observe the second frame.
  - Expected `an` sequence: 000001, 000010, …, 100000, each held 4 cycles.
  - Expected `seg` sequence: 06, 5B, 4F, 66, 6D, 7D.
  - Expected `dp`: 1 only on indices 1 and 3.
  - Expected `frame_done`: pulses every 24 cycles.
- **No tearing:** change `qm0` from 4 to 7 while index 3 is displayed → `seg` stays 66 for the rest of the frame and shows 07 at index 3 of the next frame.
- **Invalid BCD:** `qs1`=4'hB → `seg`=40 at index 4.
- **Alarm flash:**
  - Stimulus: `ALARM_FLASH_EN` defined, FLASH_FRAMES=2, hold `alarm`=1.
  - Expected: `an` normal for 2 frames, all-zero for 2 frames, repeating.
  - Drop `alarm` → normal scan resumes from the next frame.
  - Without the macro, `an` never blanks.
- **Reset mid-frame:** assert `rst` at index 4 → outputs go to 0 immediately. After release, the sequence restarts at index 0 and shows the current inputs.
